router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-control state machine of the 1x3 router. It sits directly upstream of the synchronizer and register stages.
- Watches the header byte, the per-port FIFO status and the synchronizer's soft resets.
- Drives detect_add, write_enb_reg, busy and the load-phase strobes that the synchronizer and register stages consume.
- Moore machine: all control outputs decode from the current state.

Parameters:
- WAIT_TIMEOUT, 64, cycles spent in WAIT_TILL_EMPTY before the packet is dropped (used only with ROUTER_FSM_WAIT_TIMEOUT_EN).

Ports:
- clk  input  1  router clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pkt_valid  input  1  source packet-valid.
- data_in  input  2  header address bits data_in[1:0]; sampled in DECODE_ADDRESS.
- fifo_full  input  1  full flag of the addressed FIFO (from synchronizer).
- fifo_empty_0/1/2  input  1 each  per-port FIFO empty flags.
- soft_reset_0/1/2  input  1 each  per-port soft resets (from synchronizer).
- parity_done  input  1  register stage has captured parity.
- low_pkt_valid  input  1  register stage: pkt_valid fell while the FSM was stalled.
- busy  output  1  back-pressure to source.
- detect_add  output  1  header-capture strobe.
- lfd_state  output  1  load-first-data (header) phase.
- ld_state  output  1  payload load phase.
- laf_state  output  1  load-after-full phase.
- full_state  output  1  FIFO-full stall phase.
- write_enb_reg  output  1  write qualifier to synchronizer.
- rst_int_reg  output  1  parity-check phase strobe.
- drop_pkt  output  1  packet-drop pulse (only with ROUTER_FSM_WAIT_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- State register resets asynchronously to DECODE_ADDRESS.
  - In reset: detect_add=1; every other output 0.
  - Internal 2-bit addr register resets to 0.
- addr captures data_in when state is DECODE_ADDRESS, pkt_valid=1 and data_in!=2'b11.
- sel_empty = fifo_empty_[addr]; sel_soft = soft_reset_[addr]. Both use data_in instead of addr in DECODE_ADDRESS.
- DECODE_ADDRESS:
  - Outputs: detect_add=1.
  - pkt_valid & data_in!=3 & sel_empty -> LOAD_FIRST_DATA.
  - pkt_valid & data_in!=3 & !sel_empty -> WAIT_TILL_EMPTY.
  - Otherwise stay. Address 3 is ignored: no capture, busy stays 0.
- LOAD_FIRST_DATA:
  - Outputs: lfd_state=1, busy=1.
  - -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - Outputs: ld_state=1, write_enb_reg=1, busy=0.
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE:
  - Outputs: full_state=1, busy=1, write_enb_reg=0.
  - !fifo_full -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - Outputs: laf_state=1, busy=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY:
  - Outputs: busy=1, write_enb_reg=1.
  - -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR:
  - Outputs: rst_int_reg=1, busy=1.
  - fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY:
  - Outputs: busy=1, write_enb_reg=0.
  - sel_empty -> LOAD_FIRST_DATA; else stay.
- Soft reset:
  - sel_soft=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS.
  - This overrides every transition above.
  - Soft reset of a non-addressed port has no effect.
- Latency:
  - Header to first payload write: 2 cycles when the target FIFO is empty.
  - Parity write to idle: 2 cycles.
- rst assertion mid-packet returns to DECODE_ADDRESS immediately, with no clock required.
- Illegal or unencoded state values -> DECODE_ADDRESS.

Optional Feature:
- ROUTER_FSM_WAIT_TIMEOUT_EN defined:
  - 8-bit wait counter. It clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - Counter reaching WAIT_TIMEOUT-1 with sel_empty=0 -> DECODE_ADDRESS, and drop_pkt pulses for 1 cycle.
  - Counter resets to 0 on rst.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; drop_pkt tied 0.

Decomposition:
- Shared router_pkg holds:
  - typedef enum logic [2:0] router_state_t with the 8 states, DECODE_ADDRESS encoded 3'd0.
  - localparam ADDR_INVALID = 2'b11.
  - localparam DEF_WAIT_TIMEOUT = 64.
- No sub-module: single module with a state register, next-state logic and output decode.

Test Plan:
- Reset with rst=0 mid-LOAD_DATA -> state DECODE_ADDRESS asynchronously; detect_add=1, busy=0, write_enb_reg=0.
- Packet to port 1, fifo_empty_1=1, pkt_valid high 4 cycles:
  - Required sequence: DECODE -> LFD (busy=1) -> LD (write_enb_reg=1) -> LOAD_PARITY -> CHECK_PARITY (rst_int_reg=1) -> DECODE.
- Packet to port 2 with fifo_empty_2=0 for 10 cycles -> busy=1 and write_enb_reg=0 for 10 cycles, then LFD on the cycle after fifo_empty_2=1.
- fifo_full=1 during LD for 3 cycles -> full_state=1, busy=1 for 3 cycles, then LAF.
  - With low_pkt_valid=1: -> LOAD_PARITY.
  - With parity_done=1: -> DECODE.
- data_in=2'b11 with pkt_valid=1 -> remains in DECODE_ADDRESS, busy=0.
- Soft reset in WAIT_TILL_EMPTY:
  - soft_reset_0=1 while waiting on port 0 -> DECODE next cycle.
  - soft_reset_2=1 while addr=0 -> no change.
  - With ROUTER_FSM_WAIT_TIMEOUT_EN and WAIT_TIMEOUT=8: fifo_empty_0=0 for 8 cycles -> drop_pkt=1 pulse, state returns to DECODE.

Source files
------------

// File: rtl/router_fsm_pkg.sv
// router_pkg: shared types and constants for the 1x3 router control path.
//   router_state_t   - packet-control FSM state encoding (DECODE_ADDRESS = 0)
//   ADDR_INVALID     - header address that no port answers to
//   DEF_WAIT_TIMEOUT - default WAIT_TILL_EMPTY drop limit
//   pick3()          - select one of three per-port flags by address
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_t;

  localparam logic [1:0] ADDR_INVALID     = 2'b11;
  localparam int         DEF_WAIT_TIMEOUT = 64;

  // Address 3 selects nothing, so it reads as 0 (not empty / no soft reset).
  function automatic logic pick3(input logic [1:0] a, input logic [2:0] v);
    logic r;
    r = 1'b0;
    case (a)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: control bundle between the router FSM and its neighbours
// (source, synchronizer, register stage).
//   master - environment side: drives packet/FIFO status, observes controls
//   slave  - FSM side: consumes status, drives busy/detect_add/phase strobes
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       drop_pkt;

  modport master (
    output pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_pkt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_pkt
  );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: packet-control Moore FSM of the 1x3 router.
// Ports:
//   clk  - router clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - router_fsm_if.slave: header/FIFO/soft-reset status in,
//          busy/detect_add/lfd/ld/laf/full/write_enb_reg/rst_int_reg/drop_pkt out
// Parameter WAIT_TIMEOUT: cycles in WAIT_TILL_EMPTY before a drop.
// Build macro ROUTER_FSM_WAIT_TIMEOUT_EN enables the wait-timeout drop;
// without it WAIT_TILL_EMPTY waits forever and drop_pkt is 0.
module router_fsm
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input logic        clk,
  input logic        rst,
  router_fsm_if.slave bus
);

  // 8-bit wait counter bounds the usable range.
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 256) begin : g_bad_wait_timeout
    $error("router_fsm: WAIT_TIMEOUT must be in 1..256");
  end

  router_state_t state_q, state_d;
  logic [1:0]    addr_q, addr_d;
  logic [1:0]    sel_addr;
  logic          sel_empty, sel_soft;
  logic          hdr_ok;

  // Header address is only known from data_in while still decoding.
  assign sel_addr  = (state_q == DECODE_ADDRESS) ? bus.data_in : addr_q;
  assign sel_empty = pick3(sel_addr, {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0});
  assign sel_soft  = pick3(sel_addr, {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
  assign hdr_ok    = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && hdr_ok) addr_d = bus.data_in;
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       drop_q, drop_d;
  logic       wait_expired;

  assign wait_expired = (wcnt_q == 8'(WAIT_TIMEOUT - 1));

  // Counter is held at 0 outside WAIT, so it starts from 0 on every entry.
  always_comb begin
    wcnt_d = (state_q == WAIT_TILL_EMPTY) ? wcnt_q + 8'd1 : 8'd0;
    drop_d = (state_q == WAIT_TILL_EMPTY) && !sel_empty && !sel_soft && wait_expired;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= 8'd0;
      drop_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      drop_q <= drop_d;
    end
  end

  // Registered so the pulse lands on the first DECODE_ADDRESS cycle.
  assign bus.drop_pkt = drop_q;
`else
  assign bus.drop_pkt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        else if (wait_expired) state_d = DECODE_ADDRESS;
`endif
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Soft reset of the addressed port aborts the packet from any state.
    if (state_q != DECODE_ADDRESS && sel_soft) state_d = DECODE_ADDRESS;
  end

  // Output decode
  always_comb begin
    bus.busy          = 1'b0;
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.rst_int_reg   = 1'b0;
    case (state_q)
      DECODE_ADDRESS:  bus.detect_add = 1'b1;
      LOAD_FIRST_DATA: begin bus.lfd_state = 1'b1; bus.busy = 1'b1; end
      LOAD_DATA:       begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; end
      FIFO_FULL_STATE: begin bus.full_state = 1'b1; bus.busy = 1'b1; end
      LOAD_AFTER_FULL: begin
        bus.laf_state = 1'b1; bus.busy = 1'b1; bus.write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        begin bus.busy = 1'b1; bus.write_enb_reg = 1'b1; end
      CHECK_PARITY_ERROR: begin bus.rst_int_reg = 1'b1; bus.busy = 1'b1; end
      WAIT_TILL_EMPTY:    bus.busy = 1'b1;
      default:            bus.detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scoreboard bench for router_fsm.
// Output vector order: {busy, detect_add, lfd, ld, laf, full, wen, rst_int, drop}.
module tb_router_fsm;
  import router_pkg::*;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int TB_WT   = 8;
  localparam int N_WAIT2 = 5;
`else
  localparam int TB_WT   = 64;
  localparam int N_WAIT2 = 10;
`endif

  localparam logic [8:0] O_DEC  = 9'b010000000;
  localparam logic [8:0] O_LFD  = 9'b101000000;
  localparam logic [8:0] O_LD   = 9'b000100100;
  localparam logic [8:0] O_FULL = 9'b100001000;
  localparam logic [8:0] O_LAF  = 9'b100010100;
  localparam logic [8:0] O_LP   = 9'b100000100;
  localparam logic [8:0] O_CPE  = 9'b100000010;
  localparam logic [8:0] O_WAIT = 9'b100000000;
  localparam logic [8:0] O_DROP = 9'b010000001;

  logic clk = 1'b0;
  logic rst;
  router_fsm_if bus ();

  router_fsm #(.WAIT_TIMEOUT(TB_WT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [8:0] sb[$];
  int passed = 0;
  int total  = 0;

  function automatic logic [8:0] outs();
    return {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.drop_pkt};
  endfunction

  task automatic cmp(input string tag);
    logic [8:0] e, o;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL %s: scoreboard empty, got %b", tag, outs());
    end else begin
      e = sb.pop_front();
      o = outs();
      assert (o === e) passed++;
      else $error("FAIL %s: got %b expected %b", tag, o, e);
    end
  endtask

  // Expected outputs after the next rising edge.
  task automatic exp_edge(input string tag, input logic [8:0] e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  task automatic exp_now(input string tag, input logic [8:0] e);
    sb.push_back(e);
    #1;
    cmp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.pkt_valid = 0; bus.data_in = 2'd0; bus.fifo_full = 0;
    bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
    bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
    bus.parity_done = 0; bus.low_pkt_valid = 0;
    #12;
    exp_now("reset", O_DEC);
    rst = 1'b1;

    // Port 1 packet, FIFO empty: DEC -> LFD -> LD -> LD -> LP -> CPE -> DEC
    bus.pkt_valid = 1; bus.data_in = 2'd1;
    exp_edge("p1_lfd", O_LFD);
    exp_edge("p1_ld0", O_LD);
    exp_edge("p1_ld1", O_LD);
    bus.pkt_valid = 0;
    exp_edge("p1_lp", O_LP);
    exp_edge("p1_cpe", O_CPE);
    exp_edge("p1_dec", O_DEC);

    // Port 2 busy FIFO: wait, then LFD once empty
    bus.pkt_valid = 1; bus.data_in = 2'd2; bus.fifo_empty_2 = 0;
    for (int i = 0; i < N_WAIT2; i++) exp_edge("p2_wait", O_WAIT);
    bus.fifo_empty_2 = 1;
    exp_edge("p2_lfd", O_LFD);
    exp_edge("p2_ld", O_LD);
    bus.fifo_full = 1;
    for (int i = 0; i < 3; i++) exp_edge("p2_full", O_FULL);
    bus.fifo_full = 0;
    exp_edge("p2_laf", O_LAF);
    bus.low_pkt_valid = 1;
    exp_edge("p2_laf_lp", O_LP);
    bus.low_pkt_valid = 0; bus.pkt_valid = 0;
    exp_edge("p2_cpe", O_CPE);
    exp_edge("p2_dec", O_DEC);

    // Port 0: CPE with full FIFO re-stalls, then parity_done in LAF ends packet
    bus.pkt_valid = 1; bus.data_in = 2'd0;
    exp_edge("p0_lfd", O_LFD);
    exp_edge("p0_ld", O_LD);
    bus.pkt_valid = 0;
    exp_edge("p0_lp", O_LP);
    bus.fifo_full = 1;
    exp_edge("p0_cpe", O_CPE);
    exp_edge("p0_cpe_full", O_FULL);
    bus.fifo_full = 0;
    exp_edge("p0_laf", O_LAF);
    bus.parity_done = 1;
    exp_edge("p0_pd_dec", O_DEC);
    bus.parity_done = 0;

    // Invalid address 3 is ignored
    bus.pkt_valid = 1; bus.data_in = 2'd3;
    exp_edge("a3_dec0", O_DEC);
    exp_edge("a3_dec1", O_DEC);

    // Soft resets while waiting on port 0
    bus.data_in = 2'd0; bus.fifo_empty_0 = 0;
    exp_edge("sr_wait", O_WAIT);
    bus.soft_reset_2 = 1;
    exp_edge("sr2_ignored0", O_WAIT);
    exp_edge("sr2_ignored1", O_WAIT);
    bus.soft_reset_2 = 0; bus.soft_reset_0 = 1; bus.pkt_valid = 0;
    exp_edge("sr0_dec", O_DEC);
    bus.soft_reset_0 = 0; bus.fifo_empty_0 = 1;
    exp_edge("sr0_idle", O_DEC);

    // Soft reset during payload
    bus.pkt_valid = 1; bus.data_in = 2'd1;
    exp_edge("srld_lfd", O_LFD);
    exp_edge("srld_ld", O_LD);
    bus.soft_reset_1 = 1; bus.pkt_valid = 0;
    exp_edge("sr1_ld_dec", O_DEC);
    bus.soft_reset_1 = 0;

    // Async reset mid-LD, no clock edge needed
    bus.pkt_valid = 1; bus.data_in = 2'd2;
    exp_edge("ar_lfd", O_LFD);
    exp_edge("ar_ld", O_LD);
    #2 rst = 1'b0;
    exp_now("ar_async", O_DEC);
    bus.pkt_valid = 0;
    exp_edge("ar_hold", O_DEC);
    rst = 1'b1;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Wait timeout: TB_WT cycles in WAIT, then drop pulse in DEC
    bus.pkt_valid = 1; bus.data_in = 2'd0; bus.fifo_empty_0 = 0;
    exp_edge("to_wait0", O_WAIT);
    bus.pkt_valid = 0;
    for (int i = 1; i < TB_WT; i++) exp_edge("to_wait", O_WAIT);
    exp_edge("to_drop", O_DROP);
    exp_edge("to_idle", O_DEC);
    bus.fifo_empty_0 = 1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
